// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   WIDTH_DEFAULT - default operand/result width
//   OP_*          - 5-bit opcode encodings
//   state_t       - handshake FSM states (IDLE / EXEC / DONE)
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int WIDTH_DEFAULT = 8;

   localparam logic [4:0] OP_ADD = 5'd0;
   localparam logic [4:0] OP_ADC = 5'd1;
   localparam logic [4:0] OP_SUB = 5'd2;
   localparam logic [4:0] OP_SBB = 5'd3;
   localparam logic [4:0] OP_MUL = 5'd4;
   localparam logic [4:0] OP_INR = 5'd5;
   localparam logic [4:0] OP_DCR = 5'd6;
   localparam logic [4:0] OP_AND = 5'd8;
   localparam logic [4:0] OP_OR  = 5'd9;
   localparam logic [4:0] OP_XOR = 5'd10;
   localparam logic [4:0] OP_CMA = 5'd11;
   localparam logic [4:0] OP_RLC = 5'd16;
   localparam logic [4:0] OP_RRC = 5'd17;
   localparam logic [4:0] OP_RAL = 5'd18;
   localparam logic [4:0] OP_RAR = 5'd19;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/mul8_shift_add.sv
// ---------------------------------------------------------------------------
// mul8_shift_add
// Unsigned shift-add multiplier working on operand magnitudes.
//   clk, rst_n  - clock, synchronous active-low reset (clears counter)
//   start_i     - load magnitudes and clear accumulator/counter
//   step_i      - perform one shift-add iteration
//   a_mag_i     - |A| (unsigned)
//   b_mag_i     - |B| (unsigned)
//   product_o   - accumulator value including the current iteration
//   done_o      - high while the final iteration is being stepped
// ---------------------------------------------------------------------------
module mul8_shift_add
   import alu_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEFAULT,
   parameter int MUL_ITERS = WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start_i,
   input  logic                 step_i,
   input  logic [WIDTH-1:0]     a_mag_i,
   input  logic [WIDTH-1:0]     b_mag_i,
   output logic [2*WIDTH-1:0]   product_o,
   output logic                 done_o
);

   localparam int CW = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
   localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_sum;

   always_comb begin
      // Exposed combinationally so the final step's product can be
      // registered by the core on the same edge that ends EXEC.
      acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      if (start_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_mag_i};
         acc_d    = '0;
         mplier_d = b_mag_i;
         cnt_d    = '0;
      end else if (step_i) begin
         acc_d    = acc_sum;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   assign product_o = acc_sum;
   assign done_o    = step_i && (cnt_q == LAST);

endmodule

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Sequential signed ALU on the responder side of the CPU ALU handshake.
//   clk, rst_n            - clock, synchronous active-low reset
//   opcode                - operation select, latched at accept
//   operand_A, operand_B  - signed operands, latched at accept
//   enable                - accept qualifier; low stalls EXEC
//   input_ready           - CPU request, held until result_ready is seen
//   carry_in, borrow_in   - flag inputs, latched at accept
//   result_out            - registered result, held until next completion
//   result_ready          - high while in DONE
//   carry_out, borrow_out, zero, negative, overflow - registered flags
// ---------------------------------------------------------------------------
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEFAULT,
   parameter int MUL_ITERS = WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [4:0]              opcode,
   input  logic signed [WIDTH-1:0] operand_A,
   input  logic signed [WIDTH-1:0] operand_B,
   input  logic                    enable,
   input  logic                    input_ready,
   input  logic                    carry_in,
   input  logic                    borrow_in,
   output logic signed [WIDTH-1:0] result_out,
   output logic                    result_ready,
   output logic                    carry_out,
   output logic                    borrow_out,
   output logic                    zero,
   output logic                    negative,
   output logic                    overflow
);

   localparam int W1 = WIDTH + 1;
   localparam int WX = WIDTH + 2;

   state_t             state_q, state_d;
   logic [4:0]         op_q, op_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic               cin_q, cin_d, bin_q, bin_d;
   logic [WIDTH-1:0]   res_q, res_d;
   logic               cy_q, cy_d, bw_q, bw_d, z_q, z_d, n_q, n_d, v_q, v_d;

   // Overflow of a sign-extended result: the top bits must all agree.
   function automatic logic sov(input logic [WX-1:0] x);
      return !((&x[WX-1:WIDTH-1]) || !(|x[WX-1:WIDTH-1]));
   endfunction

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
      return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
   endfunction

   // ---------------- multiplier ----------------
   logic                 mul_start, mul_step, mul_done, mul_neg, mul_ov;
   logic [2*WIDTH-1:0]   mul_mag, mul_prod;

   assign mul_start = (state_q == IDLE) && enable && input_ready;
   assign mul_step  = (state_q == EXEC) && enable && (op_q == OP_MUL);

   mul8_shift_add #(.WIDTH(WIDTH), .MUL_ITERS(MUL_ITERS)) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .start_i   (mul_start),
      .step_i    (mul_step),
      .a_mag_i   (mag(operand_A)),
      .b_mag_i   (mag(operand_B)),
      .product_o (mul_mag),
      .done_o    (mul_done)
   );

   assign mul_neg  = a_q[WIDTH-1] ^ b_q[WIDTH-1];
   assign mul_prod = mul_neg ? (~mul_mag + (2*WIDTH)'(1)) : mul_mag;
   assign mul_ov   = !((&mul_prod[2*WIDTH-1:WIDTH-1]) || !(|mul_prod[2*WIDTH-1:WIDTH-1]));

   // ---------------- single-cycle datapath ----------------
   logic [WX-1:0]     ext_a, ext_b, add_x, sub_x, inr_x, dcr_x;
   logic [W1-1:0]     usum;
   logic              ci, bi, ubrw;
   logic [WIDTH-1:0]  alu_res;
   logic              alu_cy, alu_bw, alu_v;

   always_comb begin
      ci    = (op_q == OP_ADC) ? cin_q : 1'b0;
      bi    = (op_q == OP_SBB) ? bin_q : 1'b0;
      ext_a = {{2{a_q[WIDTH-1]}}, a_q};
      ext_b = {{2{b_q[WIDTH-1]}}, b_q};
      add_x = ext_a + ext_b + WX'(ci);
      sub_x = ext_a - ext_b - WX'(bi);
      inr_x = ext_a + WX'(1);
      dcr_x = ext_a - WX'(1);
      usum  = {1'b0, a_q} + {1'b0, b_q} + W1'(ci);
      ubrw  = {1'b0, a_q} < ({1'b0, b_q} + W1'(bi));

      // Flags not produced by an opcode pass the latched inputs through.
      alu_res = a_q;
      alu_cy  = cin_q;
      alu_bw  = bin_q;
      alu_v   = 1'b0;
      case (op_q)
         OP_ADD, OP_ADC: begin alu_res = add_x[WIDTH-1:0]; alu_cy = usum[WIDTH]; alu_v = sov(add_x); end
         OP_SUB, OP_SBB: begin alu_res = sub_x[WIDTH-1:0]; alu_bw = ubrw;        alu_v = sov(sub_x); end
         OP_INR: begin alu_res = inr_x[WIDTH-1:0]; alu_v = sov(inr_x); end
         OP_DCR: begin alu_res = dcr_x[WIDTH-1:0]; alu_v = sov(dcr_x); end
         OP_AND: begin alu_res = a_q & b_q; alu_cy = 1'b0; end
         OP_OR:  begin alu_res = a_q | b_q; alu_cy = 1'b0; end
         OP_XOR: begin alu_res = a_q ^ b_q; alu_cy = 1'b0; end
         // Complement leaves carry untouched (8085 CMA behaviour).
         OP_CMA: alu_res = ~a_q;
         OP_RLC: begin alu_res = {a_q[WIDTH-2:0], a_q[WIDTH-1]}; alu_cy = a_q[WIDTH-1]; end
         OP_RRC: begin alu_res = {a_q[0], a_q[WIDTH-1:1]};       alu_cy = a_q[0]; end
         OP_RAL: begin alu_res = {a_q[WIDTH-2:0], cin_q};        alu_cy = a_q[WIDTH-1]; end
         OP_RAR: begin alu_res = {cin_q, a_q[WIDTH-1:1]};        alu_cy = a_q[0]; end
         default: ;
      endcase
   end

   // ---------------- FSM ----------------
   logic              fin;
   logic [WIDTH-1:0]  fin_res;
   logic              fin_cy, fin_bw, fin_v;

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      cin_d   = cin_q;
      bin_d   = bin_q;
      res_d   = res_q;
      cy_d    = cy_q;
      bw_d    = bw_q;
      z_d     = z_q;
      n_d     = n_q;
      v_d     = v_q;
      fin     = 1'b0;
      fin_res = alu_res;
      fin_cy  = alu_cy;
      fin_bw  = alu_bw;
      fin_v   = alu_v;

      unique case (state_q)
         IDLE: begin
            if (enable && input_ready) begin
               op_d    = opcode;
               a_d     = operand_A;
               b_d     = operand_B;
               cin_d   = carry_in;
               bin_d   = borrow_in;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (enable) begin
               if (op_q == OP_MUL) begin
                  fin     = mul_done;
                  fin_res = mul_prod[WIDTH-1:0];
                  fin_cy  = cin_q;
                  fin_bw  = bin_q;
                  fin_v   = mul_ov;
               end else begin
                  fin = 1'b1;
               end
            end
            if (fin) state_d = DONE;
         end
         DONE: begin
            if (!input_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Zero/negative are only updated at completion so outputs stay
      // all-zero after reset until the first result is registered.
      if (fin) begin
         res_d = fin_res;
         cy_d  = fin_cy;
         bw_d  = fin_bw;
         v_d   = fin_v;
         z_d   = (fin_res == '0);
         n_d   = fin_res[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cin_q   <= 1'b0;
         bin_q   <= 1'b0;
         res_q   <= '0;
         cy_q    <= 1'b0;
         bw_q    <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cin_q   <= cin_d;
         bin_q   <= bin_d;
         res_q   <= res_d;
         cy_q    <= cy_d;
         bw_q    <= bw_d;
         z_q     <= z_d;
         n_q     <= n_d;
         v_q     <= v_d;
      end
   end

   assign result_out   = res_q;
   assign result_ready = (state_q == DONE);
   assign carry_out    = cy_q;
   assign borrow_out   = bw_q;
   assign zero         = z_q;
   assign negative     = n_q;
   assign overflow     = v_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;
   import alu_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [4:0]        opcode;
   logic signed [7:0] operand_A, operand_B;
   logic              enable, input_ready, carry_in, borrow_in;
   logic signed [7:0] result_out;
   logic              result_ready, carry_out, borrow_out, zero, negative, overflow;

   always #5 clk = ~clk;

   alu_core #(.WIDTH(8), .MUL_ITERS(8)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .operand_A    (operand_A),
      .operand_B    (operand_B),
      .enable       (enable),
      .input_ready  (input_ready),
      .carry_in     (carry_in),
      .borrow_in    (borrow_in),
      .result_out   (result_out),
      .result_ready (result_ready),
      .carry_out    (carry_out),
      .borrow_out   (borrow_out),
      .zero         (zero),
      .negative     (negative),
      .overflow     (overflow)
   );

   typedef struct {
      logic [7:0] r;
      logic       c, b, z, n, v;
      int         acc;   // accept edge number
      int         lat;   // edges from accept to first ready cycle
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: plain integer arithmetic on the opcode rules.
   function automatic exp_t model(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic cin, input logic bin);
      exp_t e;
      int ua, ub, sa, sb, r, x, s;
      ua = int'(a);  ub = int'(b);
      sa = int'($signed(a));  sb = int'($signed(b));
      r = ua; e.c = cin; e.b = bin; e.v = 1'b0;
      case (op)
         OP_ADD, OP_ADC: begin
            x = (op == OP_ADC) ? int'(cin) : 0;
            r = ua + ub + x; e.c = (r > 255);
            s = sa + sb + x; e.v = (s > 127) || (s < -128);
         end
         OP_SUB, OP_SBB: begin
            x = (op == OP_SBB) ? int'(bin) : 0;
            r = ua - ub - x; e.b = (ua < ub + x);
            s = sa - sb - x; e.v = (s > 127) || (s < -128);
         end
         OP_MUL: begin r = sa * sb; e.v = (r > 127) || (r < -128); end
         OP_INR: begin r = ua + 1; e.v = (sa + 1 > 127); end
         OP_DCR: begin r = ua - 1; e.v = (sa - 1 < -128); end
         OP_AND: begin r = ua & ub; e.c = 1'b0; end
         OP_OR:  begin r = ua | ub; e.c = 1'b0; end
         OP_XOR: begin r = ua ^ ub; e.c = 1'b0; end
         OP_CMA: r = ~ua;
         OP_RLC: begin r = (ua << 1) | (ua >> 7); e.c = a[7]; end
         OP_RRC: begin r = (ua >> 1) | ((ua & 1) << 7); e.c = a[0]; end
         OP_RAL: begin r = (ua << 1) | int'(cin); e.c = a[7]; end
         OP_RAR: begin r = (ua >> 1) | (int'(cin) << 7); e.c = a[0]; end
         default: ;
      endcase
      e.r = r[7:0];
      e.z = (e.r == 8'h00);
      e.n = e.r[7];
      e.acc = 0;
      e.lat = (op == OP_MUL) ? 8 : 1;
      return e;
   endfunction

   function automatic exp_t mk(input logic [7:0] r, input logic c, input logic b, input logic z,
                               input logic n, input logic v, input int lat);
      exp_t e;
      e.r = r; e.c = c; e.b = b; e.z = z; e.n = n; e.v = v; e.acc = 0; e.lat = lat;
      return e;
   endfunction

   task automatic check_zero(input string name);
      tests++;
      if ({result_out, result_ready, carry_out, borrow_out, zero, negative, overflow} !== 14'h0) begin
         fails++;
         $display("FAIL %s: got r=%02h rdy=%0b c=%0b b=%0b z=%0b n=%0b v=%0b, expected all zero",
                  name, result_out, result_ready, carry_out, borrow_out, zero, negative, overflow);
      end
   endtask

   // Starts and ends at posedge+1.
   task automatic issue(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic bin, input int stall, input int hold,
                        input bit early, input exp_t e);
      int n;
      opcode = op; operand_A = a; operand_B = b; carry_in = cin; borrow_in = bin;
      enable = 1'b1; input_ready = 1'b1;
      e.acc = cyc + 1;
      e.lat = e.lat + stall;
      sb_q.push_back(e);
      $display("[TB] issue op=%0d A=%02h B=%02h cin=%0b bin=%0b stall=%0d hold=%0d early=%0b exp r=%02h",
               op, a, b, cin, bin, stall, hold, early, e.r);
      @(posedge clk); #1;
      // Scramble inputs to make sure the latched copies are used.
      opcode = 5'($urandom_range(0, 31)); operand_A = 8'($urandom); operand_B = 8'($urandom);
      carry_in = 1'($urandom); borrow_in = 1'($urandom);
      if (early) input_ready = 1'b0;
      if (stall > 0) begin
         enable = 1'b0;
         repeat (stall) begin @(posedge clk); #1; end
         enable = 1'b1;
      end
      n = 0;
      while (!result_ready && n < 40) begin @(posedge clk); #1; n++; end
      tests++;
      if (!result_ready) begin
         fails++;
         $display("FAIL ready_timeout: got result_ready=0 after %0d cycles, expected 1", n);
      end
      if (!early) repeat (hold) begin @(posedge clk); #1; end
      input_ready = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (result_ready !== 1'b0) begin
         fails++;
         $display("FAIL ready_release: got result_ready=%0b, expected 0", result_ready);
      end
   endtask

   // Monitor: pops an expectation on each rising result_ready and checks
   // every DONE cycle against it (covers result stability while held).
   initial begin : monitor
      exp_t cur;
      bit   prev;
      bit   have;
      prev = 1'b0; have = 1'b0;
      cur = mk(8'h00, 0, 0, 0, 0, 0, 0);
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin prev = 1'b0; have = 1'b0; continue; end
         if (result_ready && !prev) begin
            tests++;
            if (sb_q.size() == 0) begin
               fails++; have = 1'b0;
               $display("FAIL unexpected_ready: got result_ready=1 at cycle %0d, expected no pending op", cyc);
            end else begin
               cur = sb_q.pop_front(); have = 1'b1;
               tests++;
               if (cyc - cur.acc != cur.lat) begin
                  fails++;
                  $display("FAIL latency: got %0d cycles, expected %0d", cyc - cur.acc, cur.lat);
               end
            end
         end
         if (result_ready && have) begin
            tests++;
            if ({result_out, carry_out, borrow_out, zero, negative, overflow} !==
                {cur.r, cur.c, cur.b, cur.z, cur.n, cur.v}) begin
               fails++;
               $display("FAIL result: got r=%02h c=%0b b=%0b z=%0b n=%0b v=%0b, expected r=%02h c=%0b b=%0b z=%0b n=%0b v=%0b",
                        result_out, carry_out, borrow_out, zero, negative, overflow,
                        cur.r, cur.c, cur.b, cur.z, cur.n, cur.v);
            end
         end
         prev = result_ready;
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [4:0] op;
      logic [7:0] a, b;
      logic       ci, bi;
      int         st, hd;
      bit         er;

      rst_n = 1'b0; opcode = '0; operand_A = '0; operand_B = '0;
      enable = 1'b0; input_ready = 1'b0; carry_in = 1'b0; borrow_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_init");
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors.
      issue(OP_ADD, 8'h7F, 8'h01, 0, 0, 0, 0, 0, mk(8'h80, 0, 0, 0, 1, 1, 1));
      issue(OP_ADC, 8'hFF, 8'h00, 1, 0, 0, 0, 0, mk(8'h00, 1, 0, 1, 0, 0, 1));
      issue(OP_SBB, 8'h05, 8'h05, 0, 1, 0, 0, 0, mk(8'hFF, 0, 1, 0, 1, 0, 1));
      issue(OP_DCR, 8'h80, 8'h00, 0, 0, 0, 0, 0, mk(8'h7F, 0, 0, 0, 0, 1, 1));
      issue(OP_MUL, 8'hFD, 8'h05, 0, 0, 0, 0, 0, mk(8'hF1, 0, 0, 0, 1, 0, 8));
      issue(OP_MUL, 8'h10, 8'h10, 0, 0, 0, 0, 0, mk(8'h00, 0, 0, 1, 0, 1, 8));
      issue(OP_MUL, 8'h03, 8'h04, 0, 0, 2, 0, 0, mk(8'h0C, 0, 0, 0, 0, 0, 8));
      issue(OP_MUL, 8'h80, 8'h80, 0, 0, 0, 0, 0, mk(8'h00, 0, 0, 1, 0, 1, 8));
      issue(OP_RAL, 8'h81, 8'h00, 0, 0, 0, 0, 0, mk(8'h02, 1, 0, 0, 0, 0, 1));
      issue(OP_RAR, 8'h01, 8'h00, 1, 0, 0, 0, 0, mk(8'h80, 1, 0, 0, 1, 0, 1));
      issue(OP_ADD, 8'h12, 8'h34, 0, 0, 0, 5, 0, mk(8'h46, 0, 0, 0, 0, 0, 1));
      issue(OP_OR,  8'h0F, 8'hF0, 1, 0, 0, 0, 1, mk(8'hFF, 0, 0, 0, 1, 0, 1));

      // Request with enable low must not be accepted.
      opcode = OP_ADD; operand_A = 8'h01; operand_B = 8'h01;
      enable = 1'b0; input_ready = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      input_ready = 1'b0; enable = 1'b1;
      repeat (4) begin @(posedge clk); #1; end
      tests++;
      if (result_ready !== 1'b0) begin
         fails++;
         $display("FAIL no_accept: got result_ready=%0b, expected 0", result_ready);
      end
      $display("[TB] no-accept check done");

      // Reset in the middle of a multiply, after 4 iterations.
      opcode = OP_MUL; operand_A = 8'h7F; operand_B = 8'h7F;
      carry_in = 1'b1; borrow_in = 1'b1; enable = 1'b1; input_ready = 1'b1;
      @(posedge clk); #1;
      repeat (4) begin @(posedge clk); #1; end
      rst_n = 1'b0; input_ready = 1'b0;
      @(posedge clk); #1;
      check_zero("reset_mid_mul");
      $display("[TB] mid-MUL reset check done");
      rst_n = 1'b1;
      issue(OP_ADD, 8'h7F, 8'h01, 0, 0, 0, 0, 0, mk(8'h80, 0, 0, 0, 1, 1, 1));

      // Randomized traffic against the reference model.
      for (int i = 0; i < 200; i++) begin
         op = ($urandom_range(0, 3) == 0) ? OP_MUL : 5'($urandom_range(0, 31));
         a  = 8'($urandom);
         b  = 8'($urandom);
         ci = 1'($urandom);
         bi = 1'($urandom);
         st = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         hd = $urandom_range(0, 2);
         er = ($urandom_range(0, 7) == 0);
         issue(op, a, b, ci, bi, st, hd, er, model(op, a, b, ci, bi));
      end

      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (sb_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
